rtc_timekeeper: RTL and testbench

//  Parametrised BCD real-time clock core: prescaler, HH:MM:SS counters and N alarm channels.

---
 rtl/rtc_pkg.sv | 47 ++++
 rtl/rtc_prescaler.sv | 37 +++
 rtl/rtc_timekeeper.sv | 190 +++++++++++++++++++
 tb/tb_rtc_timekeeper.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rtc_pkg.sv
// Shared types, digit limits and helpers for the BCD real-time clock.
// Used by rtc_prescaler and rtc_timekeeper.
package rtc_pkg;

    typedef struct packed {
        logic [3:0] h_t;
        logic [3:0] h_u;
        logic [3:0] m_t;
        logic [3:0] m_u;
        logic [3:0] s_t;
        logic [3:0] s_u;
    } rtc_time_t;

    localparam logic [3:0] UNIT_MAX = 4'd9;
    localparam logic [3:0] TENS_MAX = 4'd5;
    localparam logic [7:0] HOUR_MAX = 8'h23;
    localparam logic [2:0] WDAY_MAX = 3'd6;

    // BCD compare against 8'h23 is exact once the hour unit digit is known to be <= 9
    function automatic logic time_valid(input rtc_time_t t);
        logic [7:0] hr;
        hr = {t.h_t, t.h_u};
        return (t.s_u <= UNIT_MAX) && (t.m_u <= UNIT_MAX) && (t.h_u <= UNIT_MAX) &&
               (t.s_t <= TENS_MAX) && (t.m_t <= TENS_MAX) && (hr <= HOUR_MAX);
    endfunction

    function automatic logic [7:0] hour_to_12h(input logic [7:0] hr);
        logic [7:0] res;
        case (hr)
            8'h00:   res = 8'h12;
            8'h13:   res = 8'h01;
            8'h14:   res = 8'h02;
            8'h15:   res = 8'h03;
            8'h16:   res = 8'h04;
            8'h17:   res = 8'h05;
            8'h18:   res = 8'h06;
            8'h19:   res = 8'h07;
            8'h20:   res = 8'h08;
            8'h21:   res = 8'h09;
            8'h22:   res = 8'h10;
            8'h23:   res = 8'h11;
            default: res = hr;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/rtc_prescaler.sv
// Divides clk down to a one-cycle tick every CLK_DIV enabled cycles.
// Clear has priority; a disabled prescaler holds its count.
module rtc_prescaler
    import rtc_pkg::*;
#(
    parameter int CLK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] r_cnt;

    assign o_tick = i_en && (r_cnt == LAST);

    // Cycle counter: clear, wrap on tick, otherwise count while enabled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (o_tick) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 1'b1;
        end else begin
            r_cnt <= r_cnt;
        end
    end

endmodule

// File: rtl/rtc_timekeeper.sv
// BCD HH:MM:SS real-time clock with validated load, 12/24 h display and N alarms.
// Optional weekday counter and per-alarm day masks when RTC_WEEKDAY_EN is defined.
module rtc_timekeeper
    import rtc_pkg::*;
#(
    parameter int CLK_DIV = 50_000_000,
    parameter int N_ALARM = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   tick_en,
    input  logic                   mode_12h,
    input  logic                   set_valid,
    input  logic [23:0]            set_time,
    output logic                   set_err,
    input  logic [N_ALARM-1:0]     alarm_en,
    input  logic [16*N_ALARM-1:0]  alarm_time,
    input  logic [N_ALARM-1:0]     alarm_ack,
    output logic [N_ALARM-1:0]     alarm_out,
    output logic [23:0]            time_bcd,
    output logic [23:0]            disp_bcd,
    output logic                   pm,
    output logic                   sec_tick,
    output logic                   day_wrap
`ifdef RTC_WEEKDAY_EN
    ,
    input  logic [2:0]             set_weekday,
    output logic [2:0]             weekday,
    input  logic [7*N_ALARM-1:0]   alarm_day_mask
`endif
);

    rtc_time_t          r_time;
    rtc_time_t          w_set;
    rtc_time_t          w_inc;
    rtc_time_t          w_next;
    logic               w_tick;
    logic               w_load_ok;
    logic               w_load_bad;
    logic               w_adv;
    logic               w_upd;
    logic               w_c_su;
    logic               w_c_st;
    logic               w_c_mu;
    logic               w_c_mt;
    logic               w_wrap;
    logic [7:0]         w_hour;
    logic [7:0]         w_disp_hr;
    logic [N_ALARM-1:0] w_trig;

    assign w_set  = rtc_time_t'(set_time);
    assign w_hour = {r_time.h_t, r_time.h_u};

`ifdef RTC_WEEKDAY_EN
    logic [2:0] r_wday;
    logic [2:0] w_wday_next;

    assign w_load_ok = set_valid && time_valid(w_set) && (set_weekday <= WDAY_MAX);
`else
    assign w_load_ok = set_valid && time_valid(w_set);
`endif

    assign w_load_bad = set_valid && !w_load_ok;
    // A load strobe, accepted or not, owns the cycle; a coinciding tick is dropped
    assign w_adv      = w_tick && !set_valid;
    assign w_upd      = w_load_ok || w_adv;

    rtc_prescaler #(
        .CLK_DIV (CLK_DIV)
    ) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .i_en   (tick_en),
        .i_clr  (w_load_ok),
        .o_tick (w_tick)
    );

    assign w_c_su = (r_time.s_u == UNIT_MAX);
    assign w_c_st = w_c_su && (r_time.s_t == TENS_MAX);
    assign w_c_mu = w_c_st && (r_time.m_u == UNIT_MAX);
    assign w_c_mt = w_c_mu && (r_time.m_t == TENS_MAX);
    assign w_wrap = w_c_mt && (w_hour == HOUR_MAX);

    // Ripple-carry BCD increment of the current time by one second
    always_comb begin
        w_inc     = r_time;
        w_inc.s_u = w_c_su ? 4'd0 : r_time.s_u + 4'd1;
        w_inc.s_t = w_c_st ? 4'd0 : (w_c_su ? r_time.s_t + 4'd1 : r_time.s_t);
        w_inc.m_u = w_c_mu ? 4'd0 : (w_c_st ? r_time.m_u + 4'd1 : r_time.m_u);
        w_inc.m_t = w_c_mt ? 4'd0 : (w_c_mu ? r_time.m_t + 4'd1 : r_time.m_t);
        if (w_wrap) begin
            w_inc.h_t = 4'd0;
            w_inc.h_u = 4'd0;
        end else if (w_c_mt && (r_time.h_u == UNIT_MAX)) begin
            w_inc.h_t = r_time.h_t + 4'd1;
            w_inc.h_u = 4'd0;
        end else if (w_c_mt) begin
            w_inc.h_t = r_time.h_t;
            w_inc.h_u = r_time.h_u + 4'd1;
        end else begin
            w_inc.h_t = r_time.h_t;
            w_inc.h_u = r_time.h_u;
        end
    end

    // Next time value: accepted load, then second increment, else hold
    always_comb begin
        w_next = r_time;
        if (w_load_ok) begin
            w_next = w_set;
        end else if (w_adv) begin
            w_next = w_inc;
        end else begin
            w_next = r_time;
        end
    end

    // Time register and its one-cycle status pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_time   <= '0;
            set_err  <= 1'b0;
            sec_tick <= 1'b0;
            day_wrap <= 1'b0;
        end else begin
            r_time   <= w_next;
            set_err  <= w_load_bad;
            sec_tick <= w_adv;
            day_wrap <= w_adv && w_wrap;
        end
    end

`ifdef RTC_WEEKDAY_EN
    // Weekday follows a load, otherwise advances on the midnight wrap
    always_comb begin
        w_wday_next = r_wday;
        if (w_load_ok) begin
            w_wday_next = set_weekday;
        end else if (w_adv && w_wrap) begin
            w_wday_next = (r_wday == WDAY_MAX) ? 3'd0 : r_wday + 3'd1;
        end else begin
            w_wday_next = r_wday;
        end
    end

    // Weekday register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wday <= 3'd0;
        end else begin
            r_wday <= w_wday_next;
        end
    end

    assign weekday = r_wday;
`endif

    for (genvar gi = 0; gi < N_ALARM; gi++) begin : g_alarm
        logic [15:0] w_at;
        logic        w_day_ok;

        assign w_at = alarm_time[16*gi +: 16];
`ifdef RTC_WEEKDAY_EN
        logic [7:0] w_mask;
        assign w_mask   = {1'b0, alarm_day_mask[7*gi +: 7]};
        assign w_day_ok = w_mask[w_wday_next];
`else
        assign w_day_ok = 1'b1;
`endif
        // Seconds are 00 only on the first update of a minute, so this fires once per minute
        assign w_trig[gi] = w_upd && alarm_en[gi] && w_day_ok &&
                            ({w_next.s_t, w_next.s_u} == 8'h00) &&
                            ({w_next.h_t, w_next.h_u, w_next.m_t, w_next.m_u} == w_at);
    end

    // Alarm flags: trigger beats ack; disable clears and blocks
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alarm_out <= '0;
        end else begin
            alarm_out <= w_trig | (alarm_out & alarm_en & ~alarm_ack);
        end
    end

    assign w_disp_hr = mode_12h ? hour_to_12h(w_hour) : w_hour;
    assign time_bcd  = r_time;
    assign disp_bcd  = {w_disp_hr, r_time.m_t, r_time.m_u, r_time.s_t, r_time.s_u};
    assign pm        = (w_hour >= 8'h12);

endmodule

// File: tb/tb_rtc_timekeeper.sv
// Randomized self-checking bench for rtc_timekeeper with a seconds-of-day reference model.
// Build with RTC_WEEKDAY_EN defined to also exercise the weekday feature.
module tb_rtc_timekeeper;

    localparam int CLK_DIV = 5;
    localparam int N_ALARM = 2;
    localparam int DAY_S   = 86400;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  tick_en;
    logic                  mode_12h;
    logic                  set_valid;
    logic [23:0]           set_time;
    logic                  set_err;
    logic [N_ALARM-1:0]    alarm_en;
    logic [16*N_ALARM-1:0] alarm_time;
    logic [N_ALARM-1:0]    alarm_ack;
    logic [N_ALARM-1:0]    alarm_out;
    logic [23:0]           time_bcd;
    logic [23:0]           disp_bcd;
    logic                  pm;
    logic                  sec_tick;
    logic                  day_wrap;
`ifdef RTC_WEEKDAY_EN
    logic [2:0]            set_weekday;
    logic [2:0]            weekday;
    logic [7*N_ALARM-1:0]  alarm_day_mask;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: plain seconds since midnight and a cycle count
    int                 m_secs;
    int                 m_pre;
    int                 m_wd;
    bit [N_ALARM-1:0]   m_al;
    bit                 m_err;
    bit                 m_stick;
    bit                 m_dwrap;

    rtc_timekeeper #(
        .CLK_DIV (CLK_DIV),
        .N_ALARM (N_ALARM)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tick_en    (tick_en),
        .mode_12h   (mode_12h),
        .set_valid  (set_valid),
        .set_time   (set_time),
        .set_err    (set_err),
        .alarm_en   (alarm_en),
        .alarm_time (alarm_time),
        .alarm_ack  (alarm_ack),
        .alarm_out  (alarm_out),
        .time_bcd   (time_bcd),
        .disp_bcd   (disp_bcd),
        .pm         (pm),
        .sec_tick   (sec_tick),
        .day_wrap   (day_wrap)
`ifdef RTC_WEEKDAY_EN
        ,
        .set_weekday    (set_weekday),
        .weekday        (weekday),
        .alarm_day_mask (alarm_day_mask)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [23:0] to_bcd(input int s);
        int h, m, c;
        h = s / 3600;
        m = (s / 60) % 60;
        c = s % 60;
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(c / 10), 4'(c % 10)};
    endfunction

    function automatic int dig(input logic [23:0] v, input int k);
        return int'(v[4*k +: 4]);
    endfunction

    function automatic bit bcd_valid(input logic [23:0] v);
        return dig(v, 0) <= 9 && dig(v, 1) <= 5 && dig(v, 2) <= 9 && dig(v, 3) <= 5 &&
               dig(v, 4) <= 9 && (dig(v, 5) * 10 + dig(v, 4)) <= 23;
    endfunction

    function automatic int bcd_secs(input logic [23:0] v);
        return (dig(v, 5) * 10 + dig(v, 4)) * 3600 + (dig(v, 3) * 10 + dig(v, 2)) * 60 +
               dig(v, 1) * 10 + dig(v, 0);
    endfunction

    function automatic int alarm_min(input int i);
        logic [23:0] a;
        a = {alarm_time[16*i +: 16], 8'h00};
        return bcd_secs(a) / 60;
    endfunction

    task automatic set_alarm(input int i, input int minute);
        logic [23:0] b;
        b = to_bcd(minute * 60);
        alarm_time[16*i +: 16] = b[23:8];
    endtask

    // Advance one clock: update the model from the applied inputs, then compare
    task automatic step();
        bit          ok;
        bit          adv;
        bit          upd;
        bit          hit;
        int          h;
        int          hd;
        logic [23:0] exp_t;
        if (rst) begin
            m_secs = 0; m_pre = 0; m_wd = 0; m_al = '0;
            m_err = 1'b0; m_stick = 1'b0; m_dwrap = 1'b0;
        end else begin
            ok = set_valid && bcd_valid(set_time);
`ifdef RTC_WEEKDAY_EN
            ok = ok && (set_weekday <= 3'd6);
`endif
            adv     = tick_en && (m_pre == CLK_DIV - 1) && !set_valid;
            m_err   = set_valid && !ok;
            m_stick = adv;
            m_dwrap = adv && (m_secs == DAY_S - 1);
            if (ok) begin
                m_secs = bcd_secs(set_time);
                m_pre  = 0;
`ifdef RTC_WEEKDAY_EN
                m_wd   = int'(set_weekday);
`endif
            end else begin
                if (tick_en) m_pre = (m_pre + 1) % CLK_DIV;
                if (adv) m_secs = (m_secs + 1) % DAY_S;
`ifdef RTC_WEEKDAY_EN
                if (m_dwrap) m_wd = (m_wd + 1) % 7;
`endif
            end
            upd = ok || adv;
            for (int i = 0; i < N_ALARM; i++) begin
                hit = upd && alarm_en[i] && (m_secs % 60 == 0) && (m_secs / 60 == alarm_min(i));
`ifdef RTC_WEEKDAY_EN
                hit = hit && alarm_day_mask[7*i + m_wd];
`endif
                if (hit) m_al[i] = 1'b1;
                else if (alarm_ack[i] || !alarm_en[i]) m_al[i] = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        exp_t = to_bcd(m_secs);
        h  = m_secs / 3600;
        hd = !mode_12h ? h : (h == 0) ? 12 : (h > 12) ? h - 12 : h;
        check_eq("time_bcd", time_bcd, exp_t);
        check_eq("disp_bcd", disp_bcd, {4'(hd / 10), 4'(hd % 10), exp_t[15:0]});
        check_eq("pm", pm, h >= 12);
        check_eq("sec_tick", sec_tick, m_stick);
        check_eq("day_wrap", day_wrap, m_dwrap);
        check_eq("set_err", set_err, m_err);
        check_eq("alarm_out", alarm_out, m_al);
`ifdef RTC_WEEKDAY_EN
        check_eq("weekday", weekday, m_wd);
`endif
    endtask

    task automatic load(input logic [23:0] v);
        set_valid = 1'b1;
        set_time  = v;
        step();
        set_valid = 1'b0;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        rst = 1'b1; tick_en = 1'b0; mode_12h = 1'b0; set_valid = 1'b0; set_time = 24'h0;
        alarm_en = '0; alarm_time = '0; alarm_ack = '0;
`ifdef RTC_WEEKDAY_EN
        set_weekday = 3'd0; alarm_day_mask = '1;
`endif
        m_secs = 0; m_pre = 0; m_wd = 0; m_al = '0; m_err = 1'b0; m_stick = 1'b0; m_dwrap = 1'b0;
        run(2);
        rst = 1'b0;

        // Midnight rollover
        tick_en = 1'b1;
        load(to_bcd(23 * 3600 + 59 * 60 + 58));
        run(12);

        // Rejected loads, including bad digits in every field
        load(24'h126100);
        load(24'h240000);
        load(24'h12005A);
        load(24'h1A0000);
        run(3);

        // Alarm at 07:30 held for the whole minute, then acknowledged
        set_alarm(0, 7 * 60 + 30);
        set_alarm(1, 23 * 60);
        alarm_en = 2'b01;
        load(to_bcd(7 * 3600 + 29 * 60 + 59));
        run(CLK_DIV * 62);
        alarm_ack = 2'b01;
        step();
        alarm_ack = 2'b00;
        run(CLK_DIV * 3);

        // 12-hour display edges
        mode_12h = 1'b1;
        load(to_bcd(5 * 60));
        load(to_bcd(13 * 3600));
        load(to_bcd(12 * 3600 + 1));
        load(to_bcd(23 * 3600 + 59 * 60));
        mode_12h = 1'b0;
        step();

        // Load on the prescaler wrap cycle, then freeze and resume
        for (int k = 0; k < CLK_DIV && m_pre != CLK_DIV - 1; k++) step();
        load(to_bcd(10 * 3600));
        run(CLK_DIV + 1);
        tick_en = 1'b0;
        run(4);
        tick_en = 1'b1;
        run(CLK_DIV);

`ifdef RTC_WEEKDAY_EN
        // Midnight alarm sees the post-wrap weekday
        set_weekday = 3'd6;
        set_alarm(1, 0);
        alarm_en = 2'b10;
        alarm_day_mask = 14'b0000001_0000000;
        load(to_bcd(DAY_S - 1));
        run(CLK_DIV + 2);
        set_weekday = 3'd7;
        load(to_bcd(100));
        set_weekday = 3'd0;
        alarm_day_mask = '1;
`endif

        // Randomized phase
        for (int n = 0; n < 3000; n++) begin
            int ch;
            tick_en   = ($urandom % 8) != 0;
            alarm_ack = ($urandom % 30 == 0) ? N_ALARM'($urandom) : '0;
            if ($urandom % 50 == 0) mode_12h = ~mode_12h;
            if ($urandom % 60 == 0) alarm_en = N_ALARM'($urandom);
            if ($urandom % 200 == 0) set_alarm($urandom % N_ALARM, $urandom_range(0, 1439));
            rst       = ($urandom % 500 == 0);
            set_valid = ($urandom % 40 == 0);
            ch        = $urandom % N_ALARM;
            case ($urandom % 3)
                0:       set_time = to_bcd((alarm_min(ch) * 60 - $urandom_range(0, 3) + DAY_S) % DAY_S);
                1:       set_time = to_bcd($urandom_range(0, DAY_S - 1));
                default: set_time = 24'($urandom);
            endcase
`ifdef RTC_WEEKDAY_EN
            set_weekday    = ($urandom % 10 == 0) ? 3'd7 : 3'($urandom_range(0, 6));
            alarm_day_mask = 14'($urandom);
`endif
            step();
        end
        rst = 1'b0;
        set_valid = 1'b0;
        run(2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
